// File: rtl/pc_fetch_sequencer.sv
// IF-stage program counter and single-outstanding instruction fetch sequencer.
// Handles hazard stalls and EX branch redirects, including redirects that land mid-fetch.
module pc_fetch_sequencer #(
   parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_0000_0000,
   parameter int          INSTR_BYTES  = 4,
   parameter int          CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             br_taken,
   input  logic [63:0]      br_target,
   output logic             imem_req,
   output logic [63:0]      imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_rdata,
   output logic             if_valid,
   output logic [63:0]      if_pc,
   output logic [31:0]      if_instr,
   output logic             flush_if,
   output logic [63:0]      pc,
   output logic [CNT_W-1:0] fetch_cnt
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [63:0]      pc_q, pc_d;
   logic [63:0]      redir_pc_q, redir_pc_d;
   logic             drop_q, drop_d;
   logic             if_valid_q, if_valid_d;
   logic [63:0]      if_pc_q, if_pc_d;
   logic [31:0]      if_instr_q, if_instr_d;
   logic             flush_if_q, flush_if_d;
   logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      redir_pc_d  = redir_pc_q;
      drop_d      = drop_q;
      if_valid_d  = if_valid_q;
      if_pc_d     = if_pc_q;
      if_instr_d  = if_instr_q;
      flush_if_d  = 1'b0;
      fetch_cnt_d = fetch_cnt_q;

      case (state_q)
         BOOT: begin
            state_d = FETCH;
         end

         FETCH: begin
            if (imem_ack) begin
               if (drop_q || br_taken) begin
                  // Stale data: retarget to the most recent redirect, EX's current one first.
                  pc_d       = br_taken ? br_target : redir_pc_q;
                  drop_d     = 1'b0;
                  flush_if_d = br_taken;
               end else begin
                  if_instr_d  = imem_rdata;
                  if_pc_d     = pc_q;
                  if_valid_d  = 1'b1;
                  pc_d        = pc_q + 64'(INSTR_BYTES);
                  fetch_cnt_d = fetch_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                  state_d     = ISSUE;
               end
            end else if (br_taken) begin
               // Address must stay put until the ack, so park the redirect.
               redir_pc_d = br_target;
               drop_d     = 1'b1;
               flush_if_d = 1'b1;
            end
         end

         ISSUE: begin
            if (br_taken) begin
               if_valid_d = 1'b0;
               flush_if_d = 1'b1;
               pc_d       = br_target;
               state_d    = FETCH;
            end else if (stall) begin
               flush_if_d = flush_if_q;
            end else begin
               if_valid_d = 1'b0;
               state_d    = FETCH;
            end
         end

         default: begin
            state_d = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= BOOT;
         pc_q        <= RESET_VECTOR;
         redir_pc_q  <= 64'd0;
         drop_q      <= 1'b0;
         if_valid_q  <= 1'b0;
         if_pc_q     <= 64'd0;
         if_instr_q  <= 32'd0;
         flush_if_q  <= 1'b0;
         fetch_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         redir_pc_q  <= redir_pc_d;
         drop_q      <= drop_d;
         if_valid_q  <= if_valid_d;
         if_pc_q     <= if_pc_d;
         if_instr_q  <= if_instr_d;
         flush_if_q  <= flush_if_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign imem_req  = (state_q == FETCH);
   assign imem_addr = pc_q;
   assign if_valid  = if_valid_q;
   assign if_pc     = if_pc_q;
   assign if_instr  = if_instr_q;
   assign flush_if  = flush_if_q;
   assign pc        = pc_q;
   assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: sequential fetch, stalls, redirects in every
// position, asynchronous reset mid-fetch and 64-bit PC wrap.
module tb_pc_fetch_sequencer;

   localparam int CNT_W = 32;
   localparam logic [31:0] NOP = 32'hD503201F;

   logic             clk;
   logic             rst_n;
   logic             stall;
   logic             br_taken;
   logic [63:0]      br_target;
   logic             imem_req;
   logic [63:0]      imem_addr;
   logic             imem_ack;
   logic [31:0]      imem_rdata;
   logic             if_valid;
   logic [63:0]      if_pc;
   logic [31:0]      if_instr;
   logic             flush_if;
   logic [63:0]      pc;
   logic [CNT_W-1:0] fetch_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   pc_fetch_sequencer #(
      .RESET_VECTOR (64'h0),
      .INSTR_BYTES  (4),
      .CNT_W        (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall      (stall),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .if_valid   (if_valid),
      .if_pc      (if_pc),
      .if_instr   (if_instr),
      .flush_if   (flush_if),
      .pc         (pc),
      .fetch_cnt  (fetch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds ack low for lat cycles checking the address is stable, then acks with data.
   task automatic do_fetch(input int lat, input logic [31:0] data, input logic [63:0] exp_addr);
      for (int i = 0; i < lat; i++) begin
         check("wait_req", 64'(imem_req), 64'd1);
         check("wait_addr", imem_addr, exp_addr);
         tick();
      end
      check("ack_addr", imem_addr, exp_addr);
      imem_ack   = 1'b1;
      imem_rdata = data;
      tick();
      imem_ack   = 1'b0;
      $display("fetch addr=%h data=%h lat=%0d if_valid=%0b cnt=%0d",
               exp_addr, data, lat, if_valid, fetch_cnt);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b1;
      stall      = 1'b0;
      br_taken   = 1'b0;
      br_target  = 64'd0;
      imem_ack   = 1'b0;
      imem_rdata = 32'd0;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_req", 64'(imem_req), 64'd0);
      check("rst_valid", 64'(if_valid), 64'd0);
      check("rst_pc", pc, 64'd0);
      check("rst_cnt", 64'(fetch_cnt), 64'd0);
      check("rst_flush", 64'(flush_if), 64'd0);
      check("rst_if_pc", if_pc, 64'd0);

      // Release; BOOT cycle ignores a branch.
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("boot_req", 64'(imem_req), 64'd0);
      br_taken  = 1'b1;
      br_target = 64'h500;
      tick();
      br_taken = 1'b0;
      check("boot_ign_addr", imem_addr, 64'h0);
      check("boot_ign_flush", 64'(flush_if), 64'd0);
      check("fetch0_req", 64'(imem_req), 64'd1);

      // Sequential fetch 0x0 and 0x4.
      do_fetch(1, NOP, 64'h0);
      check("f0_valid", 64'(if_valid), 64'd1);
      check("f0_if_pc", if_pc, 64'h0);
      check("f0_instr", 64'(if_instr), 64'(NOP));
      check("f0_cnt", 64'(fetch_cnt), 64'd1);
      check("f0_req", 64'(imem_req), 64'd0);
      check("f0_pc", pc, 64'h4);
      tick();
      check("f1_valid_lo", 64'(if_valid), 64'd0);
      check("f1_req", 64'(imem_req), 64'd1);
      do_fetch(1, 32'h8B020020, 64'h4);
      check("f1_if_pc", if_pc, 64'h4);

      // Stall in ISSUE holds everything.
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_valid", 64'(if_valid), 64'd1);
         check("stall_if_pc", if_pc, 64'h4);
         check("stall_instr", 64'(if_instr), 64'h8B020020);
         check("stall_req", 64'(imem_req), 64'd0);
         check("stall_pc", pc, 64'h8);
      end
      stall = 1'b0;
      tick();
      check("post_stall_addr", imem_addr, 64'h8);
      check("post_stall_valid", 64'(if_valid), 64'd0);
      do_fetch(1, NOP, 64'h8);
      check("f2_if_pc", if_pc, 64'h8);
      check("f2_cnt", 64'(fetch_cnt), 64'd3);

      // Branch in ISSUE.
      br_taken  = 1'b1;
      br_target = 64'h1000;
      tick();
      br_taken = 1'b0;
      check("iss_br_flush", 64'(flush_if), 64'd1);
      check("iss_br_valid", 64'(if_valid), 64'd0);
      check("iss_br_addr", imem_addr, 64'h1000);
      check("iss_br_cnt", 64'(fetch_cnt), 64'd3);
      do_fetch(1, NOP, 64'h1000);
      check("f3_flush_lo", 64'(flush_if), 64'd0);
      check("f3_if_pc", if_pc, 64'h1000);

      // Go to 0xC, then two redirects during a 4-cycle ack delay.
      br_taken  = 1'b1;
      br_target = 64'hC;
      tick();
      br_taken = 1'b0;
      check("to_c_addr", imem_addr, 64'hC);
      tick();
      check("d_c1_flush", 64'(flush_if), 64'd0);
      br_taken  = 1'b1;
      br_target = 64'h2000;
      tick();
      br_taken = 1'b0;
      check("d_c2_flush", 64'(flush_if), 64'd1);
      check("d_c2_addr", imem_addr, 64'hC);
      tick();
      check("d_c3_flush", 64'(flush_if), 64'd0);
      check("d_c3_addr", imem_addr, 64'hC);
      br_taken  = 1'b1;
      br_target = 64'h3000;
      tick();
      br_taken = 1'b0;
      check("d_c4_flush", 64'(flush_if), 64'd1);
      check("d_c4_addr", imem_addr, 64'hC);
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEADBEEF;
      tick();
      imem_ack = 1'b0;
      check("drop_valid", 64'(if_valid), 64'd0);
      check("drop_flush", 64'(flush_if), 64'd0);
      check("drop_addr", imem_addr, 64'h3000);
      check("drop_cnt", 64'(fetch_cnt), 64'd4);
      check("drop_req", 64'(imem_req), 64'd1);
      do_fetch(0, NOP, 64'h3000);
      check("f4_if_pc", if_pc, 64'h3000);
      check("f4_cnt", 64'(fetch_cnt), 64'd5);

      // Branch on the ack cycle at 0x10.
      br_taken  = 1'b1;
      br_target = 64'h10;
      tick();
      br_taken = 1'b0;
      check("to_10_addr", imem_addr, 64'h10);
      imem_ack   = 1'b1;
      imem_rdata = 32'h12345678;
      br_taken   = 1'b1;
      br_target  = 64'h40;
      tick();
      imem_ack = 1'b0;
      br_taken = 1'b0;
      check("ackbr_valid", 64'(if_valid), 64'd0);
      check("ackbr_flush", 64'(flush_if), 64'd1);
      check("ackbr_addr", imem_addr, 64'h40);
      check("ackbr_cnt", 64'(fetch_cnt), 64'd5);

      // Stall during FETCH has no effect; stall then holds ISSUE.
      stall = 1'b1;
      do_fetch(1, NOP, 64'h40);
      check("fstall_valid", 64'(if_valid), 64'd1);
      check("fstall_if_pc", if_pc, 64'h40);
      check("fstall_cnt", 64'(fetch_cnt), 64'd6);
      tick();
      check("fstall_hold", 64'(if_valid), 64'd1);
      stall = 1'b0;
      tick();
      check("pre_rst_req", 64'(imem_req), 64'd1);
      check("pre_rst_addr", imem_addr, 64'h44);

      // Asynchronous reset mid-fetch, with an ack arriving during reset.
      #2;
      rst_n    = 1'b0;
      imem_ack = 1'b1;
      #1;
      check("arst_req", 64'(imem_req), 64'd0);
      check("arst_valid", 64'(if_valid), 64'd0);
      check("arst_pc", pc, 64'd0);
      check("arst_cnt", 64'(fetch_cnt), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n    = 1'b1;
      imem_ack = 1'b0;
      #1;
      check("rboot_req", 64'(imem_req), 64'd0);
      tick();
      check("rboot_req1", 64'(imem_req), 64'd1);
      check("rboot_addr", imem_addr, 64'h0);

      // PC wrap at the top of the address space.
      do_fetch(0, NOP, 64'h0);
      check("w0_cnt", 64'(fetch_cnt), 64'd1);
      br_taken  = 1'b1;
      br_target = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      br_taken = 1'b0;
      check("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      do_fetch(1, NOP, 64'hFFFF_FFFF_FFFF_FFFC);
      check("wrap_if_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      check("wrap_pc", pc, 64'h0);
      check("wrap_cnt", 64'(fetch_cnt), 64'd2);
      tick();
      check("wrap_next_addr", imem_addr, 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Sequences the 64-bit program counter and the instruction-memory fetch handshake for the IF stage of the pipelined ARMv8 core.
- Owns the PC register and chooses its next value: sequential, branch redirect or hold.
- Issues one fetch at a time and presents the fetched word to IF/ID.
- Absorbs stalls from the hazard unit and branch redirects from EX, including redirects that arrive while a fetch is in flight.

Parameters:
- RESET_VECTOR, 64'h0000_0000_0000_0000, PC value loaded on reset.
- INSTR_BYTES, 4, PC increment per fetched instruction.
- CNT_W, 32, width of the fetched-instruction counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- stall  in  1  hazard unit: hold the current IF output.
- br_taken  in  1  EX: redirect the PC to br_target (single-cycle pulse).
- br_target  in  64  redirect address.
- imem_req  out  1  fetch request, level.
- imem_addr  out  64  fetch address.
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction.
- if_valid  out  1  if_instr/if_pc valid for IF/ID.
- if_pc  out  64  PC of if_instr.
- if_instr  out  32  fetched instruction.
- flush_if  out  1  one-cycle pulse: kill the IF/ID entry.
- pc  out  64  current PC register.
- fetch_cnt  out  CNT_W  count of delivered (non-discarded) instructions.

Behaviour:
- Reset=0 (async) forces the following, and the block holds them until Reset=1:
  - pc=RESET_VECTOR, state=BOOT.
  - imem_req=0, if_valid=0, if_pc=0, if_instr=0, flush_if=0.
  - fetch_cnt=0, drop=0, redir_pc=0.
- Outputs are registered except imem_req and imem_addr, which are decoded from state/pc.
- States:
  - BOOT: one cycle after reset release; br_taken ignored; -> FETCH.
  - FETCH: imem_req=1, imem_addr=pc. imem_addr must stay stable while imem_req=1 and no ack has arrived.
  - ISSUE: imem_req=0, if_valid=1.
- FETCH, imem_ack=0:
  - br_taken=1 -> redir_pc<=br_target, drop<=1, flush_if pulse. Stay in FETCH; address is unchanged.
  - A later br_taken overwrites redir_pc (latest redirect wins).
- FETCH, imem_ack=1:
  - Discard imem_rdata when drop=1 or br_taken=1.
  - Then pc <= (br_taken ? br_target : redir_pc), drop<=0, and stay in FETCH. The new address appears the next cycle.
  - A br_taken on the ack cycle also pulses flush_if and takes priority over redir_pc.
- FETCH, imem_ack=1, no redirect:
  - if_instr<=imem_rdata, if_pc<=pc, if_valid<=1.
  - pc<=pc+INSTR_BYTES (mod 2^64 wrap), fetch_cnt<=fetch_cnt+1 (wraps), -> ISSUE.
- ISSUE, priority order:
  1. br_taken: if_valid<=0, flush_if pulse, pc<=br_target, -> FETCH.
  2. stall: hold every output unchanged.
  3. Otherwise: if_valid<=0, -> FETCH.
- Latency: ack to if_valid is 1 cycle.
- Steady-state throughput: 1 instruction per (mem latency + 2) cycles.
- stall in FETCH has no effect; the in-flight fetch completes.
- flush_if is never high for two consecutive cycles unless br_taken is high on both.
- Reset asserted mid-fetch: imem_req drops immediately (async), the outstanding ack is ignored, and the FSM restarts at BOOT.

Test Plan:
- Reset release, imem acks 1 cycle after each req with rdata=32'hD503201F → imem_addr sequence 0x0, 0x4, 0x8; if_valid pulses carry if_pc 0x0, 0x4, 0x8; fetch_cnt=3.
- Stall held 5 cycles while ISSUE holds if_pc=0x4 → if_valid stays 1, if_pc/if_instr constant, imem_req=0, pc=0x8 throughout; the next fetch addresses 0x8.
- br_taken with br_target=0x1000 while in ISSUE at if_pc=0x8 → flush_if 1 cycle, if_valid=0, next imem_addr=0x1000, fetch_cnt unchanged.
- Ack delayed 4 cycles at addr 0xC; br_taken target=0x2000 at cycle 1, then target=0x3000 at cycle 3 → imem_addr stays 0xC until ack, rdata is discarded (no if_valid), next imem_addr=0x3000, two flush_if pulses.
- br_taken with target=0x40 in the same cycle as ack at addr 0x10 → data discarded, next imem_addr=0x40.
- Reset=0 asserted mid-FETCH → imem_req and if_valid drop without a clock edge; after release, a one-cycle BOOT, then imem_addr=RESET_VECTOR.
- pc=64'hFFFF_FFFF_FFFF_FFFC fetch completes → pc wraps to 0x0.
